shift_rotate_unit: RTL

Parametrised multi-cycle shift/rotate execution unit for the datapath ALU. It generalises the single arithmetic-right-shift path to five operations (SHR, SHRA, SHL, ROR, ROL), a configurable data width and a configurable bits-per-cycle step. It uses a start/busy/done handshake and latches its result for the Z-low register path. It sits beside the combinational ALU, fed by the Y register (operand) and the bus (amount).

---
 rtl/shift_rotate_unit_pkg.sv | 60 ++++++
 rtl/shift_rotate_unit_shift_step.sv | 39 +++
 rtl/shift_rotate_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/shift_rotate_unit_pkg.sv
// -----------------------------------------------------------------------------
// shift_rotate_unit_pkg
// Shared definitions for the multi-cycle shift/rotate execution unit:
//   - operation encodings (3-bit op field driven by the control unit)
//   - FSM state type
//   - helpers to qualify an op and to derive the effective shift amount
// -----------------------------------------------------------------------------
package shift_rotate_unit_pkg;

  // Operation encodings; 3'b101..3'b111 are illegal and flagged through err.
  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // True for the five defined encodings.
  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal_v;
    case (op)
      OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: legal_v = 1'b1;
      default:                                 legal_v = 1'b0;
    endcase
    return legal_v;
  endfunction

  // Effective shift count.
  //   amt_sat : the full-width amount is >= width (only meaningful for shifts)
  //   amt_low : the amount's low clog2(width)+1 bits, zero-extended
  //   width   : datapath width (power of two)
  // Shifts saturate at width; rotates reduce modulo width; illegal ops do
  // not move the operand at all. When amt_sat is clear the amount is below
  // width, so its low bits alone carry the whole value.
  function automatic logic [31:0] calc_eff(
    input logic [2:0]  op,
    input logic        amt_sat,
    input logic [31:0] amt_low,
    input logic [31:0] width
  );
    logic [31:0] eff_v;
    case (op)
      OP_SHR, OP_SHRA, OP_SHL: begin
        if (amt_sat) begin
          eff_v = width;
        end else begin
          eff_v = amt_low;
        end
      end
      OP_ROR, OP_ROL: eff_v = amt_low & (width - 32'd1);
      default:        eff_v = 32'd0;
    endcase
    return eff_v;
  endfunction

endpackage

// File: rtl/shift_rotate_unit_shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational single-step shifter/rotator used by shift_rotate_unit.
// Moves acc by k bit positions (0..STEP) according to op.
//   acc     in  DATA_WIDTH        current accumulator value
//   op      in  3                 operation select (package encodings)
//   k       in  clog2(STEP)+1     step size for this cycle, 0..STEP
//   shifted out DATA_WIDTH        acc after the step (acc for illegal op)
// -----------------------------------------------------------------------------
module shift_step
  import shift_rotate_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = 4,
  localparam int K_W       = $clog2(STEP) + 1
) (
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [2:0]            op,
  input  logic [K_W-1:0]        k,
  output logic [DATA_WIDTH-1:0] shifted
);

  logic [2*DATA_WIDTH-1:0] dbl_s;

  // Select the shifted/rotated value; rotates come from a doubled copy of acc
  // so the bits leaving one end reappear at the other.
  always_comb begin
    dbl_s = {acc, acc};
    case (op)
      OP_SHR:  shifted = acc >> k;
      OP_SHRA: shifted = DATA_WIDTH'($signed(acc) >>> k);
      OP_SHL:  shifted = acc << k;
      OP_ROR:  shifted = DATA_WIDTH'(dbl_s >> k);
      OP_ROL:  shifted = DATA_WIDTH'((dbl_s << k) >> DATA_WIDTH);
      default: shifted = acc;
    endcase
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// -----------------------------------------------------------------------------
// shift_rotate_unit
// Multi-cycle shift/rotate execution unit (SHR, SHRA, SHL, ROR, ROL) moving
// at most STEP bits per clock, with a start/busy/done handshake and a
// latched result for the Z-low register path.
//   Clock   in  1           system clock, rising edge
//   Resetn  in  1           asynchronous active-low reset
//   start   in  1           request, accepted only while idle
//   op      in  3           operation select (see package)
//   operand in  DATA_WIDTH  value to shift (from Y)
//   amount  in  DATA_WIDTH  shift count (full bus value)
//   busy    out 1           operation in progress
//   done    out 1           one-cycle pulse, result valid
//   err     out 1           illegal op, valid with done, held to next accept
//   result  out DATA_WIDTH  shifted value, held until the next done
// -----------------------------------------------------------------------------
module shift_rotate_unit
  import shift_rotate_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = 4
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [DATA_WIDTH-1:0] amount,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result
);

  // rem holds 0..DATA_WIDTH, k holds 0..STEP.
  localparam int REM_W = $clog2(DATA_WIDTH) + 1;
  localparam int K_W   = $clog2(STEP) + 1;

  state_e                state_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic [DATA_WIDTH-1:0] acc_r;
  logic [REM_W-1:0]      rem_r;
  logic [2:0]            op_r;

  logic                  amt_sat_s;
  logic [31:0]           amt_low_s;
  logic [REM_W-1:0]      eff_s;
  logic [K_W-1:0]        k_s;
  logic [DATA_WIDTH-1:0] step_out_s;

  // Effective amount for a new request; the saturation test looks at every
  // bit of the bus so huge counts still clamp to DATA_WIDTH for shifts.
  always_comb begin
    amt_sat_s = (amount >= DATA_WIDTH'(DATA_WIDTH));
    amt_low_s = 32'(amount[REM_W-1:0]);
    eff_s     = REM_W'(calc_eff(op, amt_sat_s, amt_low_s, 32'(DATA_WIDTH)));
  end

  // Bits to move this cycle: the full step, or whatever is left.
  always_comb begin
    if (rem_r > REM_W'(STEP)) begin
      k_s = K_W'(STEP);
    end else begin
      k_s = rem_r[K_W-1:0];
    end
  end

  shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP)
  ) u_shift_step (
    .acc     (acc_r),
    .op      (op_r),
    .k       (k_s),
    .shifted (step_out_s)
  );

  // Control FSM, remaining-count datapath and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      result_r <= '0;
      acc_r    <= '0;
      rem_r    <= '0;
      op_r     <= OP_SHR;
    end else begin
      case (state_r)
        IDLE: begin
          // done is a single-cycle pulse; it falls on the edge after it rose.
          done_r <= 1'b0;
          if (start) begin
            op_r    <= op;
            acc_r   <= operand;
            rem_r   <= eff_s;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          if (rem_r != '0) begin
            acc_r  <= step_out_s;
            rem_r  <= rem_r - REM_W'(k_s);
            done_r <= 1'b0;
          end else begin
            // Completion edge: publish result; a start in the done cycle
            // is taken by IDLE on the next edge.
            result_r <= acc_r;
            done_r   <= 1'b1;
            err_r    <= ~is_legal_op(op_r);
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;
  assign result = result_r;

endmodule
